id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage. Sits directly upstream of the ALU and drives its in1, in2, ctrl and PC inputs.
- Captures decoded instructions from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards: stalls ID and inserts a bubble.
- Honours downstream hold and branch flush.

Parameters:
- XLEN, 32, datapath width
- REGW, 5, register-index width
- CNTW, 16, width of bubble performance counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2  in  REGW  source register indices
- id_rd  in  REGW  destination index
- id_rs1_val, id_rs2_val  in  XLEN  register-file read data
- id_imm  in  XLEN  immediate (upper-immediate ops supply imm[31:12] right-aligned; ALU shifts)
- id_alu_ctrl  in  4  ALU opcode (0x0–0xB)
- id_use_imm  in  1  in2 takes immediate instead of rs2
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- exmem_rd  in  REGW; exmem_reg_write  in  1; exmem_result  in  XLEN  EX/MEM forward source
- memwb_rd  in  REGW; memwb_reg_write  in  1; memwb_result  in  XLEN  MEM/WB forward source
- flush  in  1  branch taken (registered from ALU branch_taken at EX/MEM)
- hold  in  1  downstream cannot accept
- alu_in1, alu_in2  out  XLEN  ALU operands
- alu_ctrl  out  4; alu_pc  out  XLEN
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each
- ex_rd  out  REGW
- ex_store_data  out  XLEN  forwarded rs2 for stores
- id_stall  out  1  ID/IF must hold
- bubble_count  out  CNTW  saturating count of inserted bubbles

Behaviour:
- Reset (async, immediate): all EX registers 0; ex_valid=0; all control outputs 0; alu_ctrl=0 (ADD); bubble_count=0. Outputs are 0 while rst is high.
- Register update priority on each rising edge: flush > hold > load-use bubble > load.
  - flush: ex_valid and control bits cleared; datapath registers keep value.
  - hold: every register keeps its value.
  - load-use bubble: same clearing as flush; bubble_count increments, saturating at all-ones.
  - load: capture all id_* fields.
- Load-use hazard = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | (ex_rd==id_rs2 & !id_use_imm)).
- id_stall = (hazard & !flush) | hold. Combinational.
- Control outputs are qualified: ex_reg_write/mem_read/mem_write are never 1 while ex_valid=0.
- Forwarding is combinational on registered ex_rs1/ex_rs2 and uses the first matching source:
  1. EX/MEM if exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rsN
  2. MEM/WB under the same conditions
  3. the registered register-file value
- x0 is never forwarded.
- alu_in1 = forwarded rs1.
- alu_in2 = id_use_imm ? registered imm : forwarded rs2.
- ex_store_data = forwarded rs2 regardless of use_imm.
- Latency: one cycle from ID capture to operands at the ALU. Forwarding adds zero cycles.
- Flush in the same cycle as a hazard: flush wins, id_stall=0, bubble_count unchanged.
- hold during a hazard: id_stall=1, no bubble, counter unchanged.

Decomposition:
- Shared package (riscv_pkg):
  - ALU opcode constants ALU_ADD..ALU_AUIPC (0x0–0xB)
  - forward-select enum FWD_RF/FWD_MEM/FWD_WB
  - XLEN and REGW constants
- One sub-module, forward_unit: purely combinational. Takes rsN and both forward sources and returns the select. Instantiated twice, for rs1 and rs2.

Test Plan:
- Reset mid-operation: ex_valid=1, assert rst between edges -> all outputs 0 immediately; bubble_count=0.
- ADD x3,x1,x2 with rf x1=5, x2=7; no forwards -> next cycle alu_in1=5, alu_in2=7, alu_ctrl=0, ex_rd=3, ex_valid=1.
- exmem_rd=1 with result 100 and memwb_rd=1 with result 200, both reg_write=1 -> alu_in1=100. Same with exmem_rd=0 -> alu_in1=200.
- LW x4 in EX (mem_read=1), ID holds ADD x5,x4,x1 -> id_stall=1 for one cycle; next edge ex_valid=0, ex_reg_write=0, bubble_count=1. Following cycle ADD captured with no stall.
- Hazard with flush=1 in the same cycle -> id_stall=0, EX becomes bubble, bubble_count unchanged.
- hold=1 for 3 cycles with SUB in EX -> alu_in1, alu_in2, alu_ctrl=1 stable; id_stall=1. Writes to x0 with exmem_rd=0 are never forwarded.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath widths, ALU opcodes and
// forwarding-source select used by the ID/EX stage.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_SLL   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SRA   = 4'h7;
  localparam logic [3:0] ALU_SLT   = 4'h8;
  localparam logic [3:0] ALU_SLTU  = 4'h9;
  localparam logic [3:0] ALU_LUI   = 4'hA;
  localparam logic [3:0] ALU_AUIPC = 4'hB;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// Operand-forward source selection for one source register.
// EX/MEM is the younger result and therefore wins over MEM/WB; x0 never forwards.
module forward_unit #(
  parameter int REGW = riscv_pkg::REGW
) (
  input  logic [REGW-1:0]    rs,
  input  logic [REGW-1:0]    exmem_rd,
  input  logic               exmem_reg_write,
  input  logic [REGW-1:0]    memwb_rd,
  input  logic               memwb_reg_write,
  output riscv_pkg::fwd_sel_e sel
);
  import riscv_pkg::*;

  always_comb begin
    sel = FWD_RF;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion,
// downstream hold and branch flush. Feeds the ALU operands one cycle after ID.
module id_ex_stage #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int REGW = riscv_pkg::REGW,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_ctrl,
  input  logic            id_use_imm,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic [REGW-1:0] exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [REGW-1:0] memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  input  logic            flush,
  input  logic            hold,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_pc,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [REGW-1:0] ex_rd,
  output logic [XLEN-1:0] ex_store_data,
  output logic            id_stall,
  output logic [CNTW-1:0] bubble_count
);
  import riscv_pkg::*;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic            vld_p1;
  logic            reg_write_p1;
  logic            mem_read_p1;
  logic            mem_write_p1;
  logic            use_imm_p1;
  logic [XLEN-1:0] pc_p1;
  logic [REGW-1:0] rs1_p1;
  logic [REGW-1:0] rs2_p1;
  logic [REGW-1:0] rd_p1;
  logic [XLEN-1:0] rs1_val_p1;
  logic [XLEN-1:0] rs2_val_p1;
  logic [XLEN-1:0] imm_p1;
  logic [3:0]      ctrl_p1;
  logic [CNTW-1:0] bubble_cnt;

  logic            load_use;
  fwd_sel_e        sel_rs1;
  fwd_sel_e        sel_rs2;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // A load in EX cannot supply its data until MEM, so a dependent ID instruction must wait.
  assign load_use = vld_p1 && mem_read_p1 && (rd_p1 != '0) && id_valid &&
                    ((rd_p1 == id_rs1) || ((rd_p1 == id_rs2) && !id_use_imm));

  assign id_stall = !rst && ((load_use && !flush) || hold);

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      use_imm_p1   <= 1'b0;
      pc_p1        <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
      rs1_val_p1   <= '0;
      rs2_val_p1   <= '0;
      imm_p1       <= '0;
      ctrl_p1      <= ALU_ADD;
      bubble_cnt   <= '0;
    end else if (flush) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
    end else if (hold) begin
      vld_p1       <= vld_p1;
    end else if (load_use) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      bubble_cnt   <= sat_inc(bubble_cnt);
    end else begin
      vld_p1       <= id_valid;
      reg_write_p1 <= id_reg_write;
      mem_read_p1  <= id_mem_read;
      mem_write_p1 <= id_mem_write;
      use_imm_p1   <= id_use_imm;
      pc_p1        <= id_pc;
      rs1_p1       <= id_rs1;
      rs2_p1       <= id_rs2;
      rd_p1        <= id_rd;
      rs1_val_p1   <= id_rs1_val;
      rs2_val_p1   <= id_rs2_val;
      imm_p1       <= id_imm;
      ctrl_p1      <= id_alu_ctrl;
    end
  end

  forward_unit #(.REGW(REGW)) u_fwd_rs1 (
    .rs              (rs1_p1),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .sel             (sel_rs1)
  );

  forward_unit #(.REGW(REGW)) u_fwd_rs2 (
    .rs              (rs2_p1),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .sel             (sel_rs2)
  );

  always_comb begin
    rs1_fwd = rs1_val_p1;
    case (sel_rs1)
      FWD_MEM: rs1_fwd = exmem_result;
      FWD_WB:  rs1_fwd = memwb_result;
      default: rs1_fwd = rs1_val_p1;
    endcase
  end

  always_comb begin
    rs2_fwd = rs2_val_p1;
    case (sel_rs2)
      FWD_MEM: rs2_fwd = exmem_result;
      FWD_WB:  rs2_fwd = memwb_result;
      default: rs2_fwd = rs2_val_p1;
    endcase
  end

  assign alu_in1       = rs1_fwd;
  assign alu_in2       = use_imm_p1 ? imm_p1 : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign alu_ctrl      = ctrl_p1;
  assign alu_pc        = pc_p1;
  assign ex_rd         = rd_p1;
  assign ex_valid      = vld_p1;
  assign ex_reg_write  = vld_p1 && reg_write_p1;
  assign ex_mem_read   = vld_p1 && mem_read_p1;
  assign ex_mem_write  = vld_p1 && mem_write_p1;
  assign bubble_count  = bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the EX-stage contents.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int CNTW = 4;
  localparam int VW   = 4*XLEN + 4 + 4 + REGW + 1 + CNTW;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [REGW-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rs1_val, id_rs2_val, id_imm;
  logic [3:0]      id_alu_ctrl;
  logic            id_use_imm, id_reg_write, id_mem_read, id_mem_write;
  logic [REGW-1:0] exmem_rd, memwb_rd;
  logic            exmem_reg_write, memwb_reg_write;
  logic [XLEN-1:0] exmem_result, memwb_result;
  logic            flush, hold;
  logic [XLEN-1:0] alu_in1, alu_in2, alu_pc, ex_store_data;
  logic [3:0]      alu_ctrl;
  logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [REGW-1:0] ex_rd;
  logic            id_stall;
  logic [CNTW-1:0] bubble_count;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the instruction currently sitting in EX.
  logic            m_valid, m_rw, m_mr, m_mw, m_ui;
  logic [XLEN-1:0] m_pc, m_v1, m_v2, m_imm;
  logic [REGW-1:0] m_rs1, m_rs2, m_rd;
  logic [3:0]      m_ctrl;
  logic [CNTW-1:0] m_cnt;

  id_ex_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_alu_ctrl(id_alu_ctrl), .id_use_imm(id_use_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .flush(flush), .hold(hold),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_pc(alu_pc),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .id_stall(id_stall), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  wire [VW-1:0] act_vec = {alu_in1, alu_in2, alu_ctrl, alu_pc, ex_valid, ex_reg_write,
                           ex_mem_read, ex_mem_write, ex_rd, ex_store_data, id_stall,
                           bubble_count};

  function automatic logic [XLEN-1:0] fwd_val(input logic [REGW-1:0] rs, input logic [XLEN-1:0] rf);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
    return rf;
  endfunction

  function automatic logic m_hazard();
    return m_valid && m_mr && m_rd != 0 && id_valid &&
           (m_rd == id_rs1 || (m_rd == id_rs2 && !id_use_imm));
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic stall;
    stall = !rst && ((m_hazard() && !flush) || hold);
    return {fwd_val(m_rs1, m_v1), (m_ui ? m_imm : fwd_val(m_rs2, m_v2)), m_ctrl, m_pc,
            m_valid, m_valid & m_rw, m_valid & m_mr, m_valid & m_mw, m_rd,
            fwd_val(m_rs2, m_v2), stall, m_cnt};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ui = 0;
    m_pc = 0; m_v1 = 0; m_v2 = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_ctrl = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (rst) model_reset();
    else if (flush) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    end else if (hold) begin
    end else if (m_hazard()) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
      if (m_cnt != {CNTW{1'b1}}) m_cnt = m_cnt + 1;
    end else begin
      m_valid = id_valid; m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write;
      m_ui = id_use_imm; m_pc = id_pc; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_v1 = id_rs1_val; m_v2 = id_rs2_val; m_imm = id_imm; m_ctrl = id_alu_ctrl;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [XLEN-1:0] pc,
                          input logic [REGW-1:0] rs1, input logic [REGW-1:0] rs2,
                          input logic [REGW-1:0] rd, input logic [XLEN-1:0] v1,
                          input logic [XLEN-1:0] v2, input logic [XLEN-1:0] imm,
                          input logic [3:0] ctrl, input logic ui, input logic rw,
                          input logic mr, input logic mw);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_val = v1; id_rs2_val = v2; id_imm = imm; id_alu_ctrl = ctrl;
    id_use_imm = ui; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic set_fwd(input logic [REGW-1:0] er, input logic ew, input logic [XLEN-1:0] eres,
                         input logic [REGW-1:0] wr, input logic ww, input logic [XLEN-1:0] wres);
    exmem_rd = er; exmem_reg_write = ew; exmem_result = eres;
    memwb_rd = wr; memwb_reg_write = ww; memwb_result = wres;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (act_vec !== '0) begin
      n_err++; $display("FAIL reset_state: got %h want 0", act_vec);
    end
    drive_id(1, 32'h40, 1, 2, 3, 32'h11, 32'h22, 32'h33, 4'h2, 0, 1, 1, 1);
    tick();
    n_cmp++;
    if (ex_valid !== 1'b1) begin
      n_err++; $display("FAIL reset_preload_valid: got %b want 1", ex_valid);
    end
    #2 rst = 1; hold = 1;
    model_reset();
    #1;
    n_cmp++;
    if (act_vec !== '0) begin
      n_err++; $display("FAIL reset_async: got %h want 0", act_vec);
    end
    n_cmp++;
    if (bubble_count !== '0) begin
      n_err++; $display("FAIL reset_bubble: got %0d want 0", bubble_count);
    end
    @(negedge clk);
    rst = 0; hold = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    set_fwd(0, 0, 0, 0, 0, 0);
    drive_id(1, 32'h80, 1, 2, 3, 5, 7, 32'h0, 4'h0, 0, 1, 0, 0);
    tick();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({alu_in1, alu_in2, alu_ctrl, ex_rd, ex_valid} !== {32'd5, 32'd7, 4'h0, 5'd3, 1'b1}) begin
      n_err++;
      $display("FAIL add: got in1=%0d in2=%0d ctrl=%0d rd=%0d v=%b want 5 7 0 3 1",
               alu_in1, alu_in2, alu_ctrl, ex_rd, ex_valid);
    end
  endtask

  task automatic test_forward();
    set_fwd(1, 1, 100, 1, 1, 200);
    #1;
    n_cmp++;
    if (alu_in1 !== 32'd100) begin
      n_err++; $display("FAIL fwd_exmem_priority: got %0d want 100", alu_in1);
    end
    set_fwd(0, 1, 100, 1, 1, 200);
    #1;
    n_cmp++;
    if (alu_in1 !== 32'd200) begin
      n_err++; $display("FAIL fwd_memwb: got %0d want 200", alu_in1);
    end
    set_fwd(2, 1, 300, 0, 0, 0);
    #1;
    n_cmp++;
    if ({alu_in2, ex_store_data} !== {32'd300, 32'd300}) begin
      n_err++; $display("FAIL fwd_rs2: got in2=%0d st=%0d want 300 300", alu_in2, ex_store_data);
    end
    set_fwd(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_use();
    logic [CNTW-1:0] c0;
    c0 = m_cnt;
    drive_id(1, 32'h100, 2, 0, 4, 9, 0, 16, 4'h0, 1, 1, 1, 0);
    tick();
    drive_id(1, 32'h104, 4, 1, 5, 0, 5, 0, 4'h0, 0, 1, 0, 0);
    #1;
    n_cmp++;
    if (id_stall !== 1'b1) begin
      n_err++; $display("FAIL loaduse_stall: got %b want 1", id_stall);
    end
    tick();
    n_cmp++;
    if ({ex_valid, ex_reg_write, bubble_count, id_stall} !== {1'b0, 1'b0, c0 + 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL loaduse_bubble: got v=%b rw=%b cnt=%0d stall=%b want 0 0 %0d 0",
               ex_valid, ex_reg_write, bubble_count, id_stall, c0 + 4'd1);
    end
    tick();
    n_cmp++;
    if ({ex_valid, ex_rd, alu_pc} !== {1'b1, 5'd5, 32'h104}) begin
      n_err++; $display("FAIL loaduse_resume: got v=%b rd=%0d pc=%h want 1 5 104",
                        ex_valid, ex_rd, alu_pc);
    end
  endtask

  task automatic test_flush_hazard();
    logic [CNTW-1:0] c0;
    drive_id(1, 32'h200, 1, 0, 6, 0, 0, 4, 4'h0, 1, 1, 1, 0);
    tick();
    c0 = m_cnt;
    drive_id(1, 32'h204, 6, 0, 7, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    flush = 1;
    #1;
    n_cmp++;
    if (id_stall !== 1'b0) begin
      n_err++; $display("FAIL flush_hazard_stall: got %b want 0", id_stall);
    end
    tick();
    flush = 0;
    n_cmp++;
    if ({ex_valid, ex_mem_read, bubble_count} !== {1'b0, 1'b0, c0}) begin
      n_err++; $display("FAIL flush_hazard_ex: got v=%b mr=%b cnt=%0d want 0 0 %0d",
                        ex_valid, ex_mem_read, bubble_count, c0);
    end
  endtask

  task automatic test_hold();
    drive_id(1, 32'h300, 1, 2, 8, 11, 22, 0, 4'h1, 0, 1, 0, 0);
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
               $urandom, 4'($urandom_range(11)), 1'($urandom), 1, 1'($urandom), 0);
      #1;
      n_cmp++;
      if (id_stall !== 1'b1) begin
        n_err++; $display("FAIL hold_stall[%0d]: got %b want 1", i, id_stall);
      end
      tick();
      n_cmp++;
      if ({alu_in1, alu_in2, alu_ctrl, ex_valid} !== {32'd11, 32'd22, 4'h1, 1'b1}) begin
        n_err++; $display("FAIL hold_stable[%0d]: got %0d %0d %0d %b want 11 22 1 1",
                          i, alu_in1, alu_in2, alu_ctrl, ex_valid);
      end
    end
    hold = 0;
  endtask

  task automatic test_x0();
    drive_id(1, 32'h400, 0, 0, 9, 0, 0, 0, 4'h0, 0, 1, 0, 1);
    tick();
    set_fwd(0, 1, 555, 0, 1, 777);
    #1;
    n_cmp++;
    if ({alu_in1, alu_in2, ex_store_data} !== '0) begin
      n_err++; $display("FAIL x0_no_forward: got %0d %0d %0d want 0 0 0",
                        alu_in1, alu_in2, ex_store_data);
    end
    set_fwd(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      drive_id(1, 32'h500, 2, 3, 1, 0, 0, 0, 4'h0, 1, 1, 1, 0);
      tick();
      drive_id(1, 32'h504, 1, 2, 6, 0, 0, 0, 4'h0, 0, 1, 0, 0);
      tick();
    end
    n_cmp++;
    if (bubble_count !== {CNTW{1'b1}}) begin
      n_err++; $display("FAIL bubble_saturate: got %0d want %0d", bubble_count, {CNTW{1'b1}});
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] e;
    for (int i = 0; i < 300; i++) begin
      drive_id($urandom_range(9) != 0, $urandom, 5'($urandom_range(3)), 5'($urandom_range(3)),
               5'($urandom_range(3)), $urandom, $urandom, $urandom, 4'($urandom_range(11)),
               1'($urandom), 1'($urandom), $urandom_range(2) == 0, 1'($urandom));
      set_fwd(5'($urandom_range(3)), 1'($urandom), $urandom,
              5'($urandom_range(3)), 1'($urandom), $urandom);
      flush = ($urandom_range(11) == 0);
      hold  = ($urandom_range(7) == 0);
      #1;
      e = exp_vec();
      n_cmp++;
      if (act_vec !== e) begin
        n_err++; $display("FAIL random_comb[%0d]: got %h want %h", i, act_vec, e);
      end
      tick();
      e = exp_vec();
      n_cmp++;
      if (act_vec !== e) begin
        n_err++; $display("FAIL random_reg[%0d]: got %h want %h", i, act_vec, e);
      end
    end
    flush = 0; hold = 0;
  endtask

  initial begin
    rst = 1; flush = 0; hold = 0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_flush_hazard();
    test_hold();
    test_x0();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
